audio_dac_serializer: RTL and testbench
=======================================

# audio_dac_serializer

Playback-side endpoint of the codec sample handshake. Accepts stereo sample pairs from user logic via `write`/`write_ready`, buffers them in a small FIFO, and shifts them out MSB-first on `AUD_DACDAT` in I2S format. Timing comes from the codec-mastered `AUD_BCLK`/`AUD_DACLRCK`, which are sampled in the `CLOCK_50` domain. It sits between the sample-processing block and the `AUD_DACDAT` pin, and mirrors the ADC capture path.

## Interface

Parameters:
- `DATA_WIDTH`, 24: bits per channel sample.
- `FIFO_DEPTH`, 4: stereo pairs buffered; power of two, ≥2.

Ports:
- `CLOCK_50`  in  1  sole clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `write`  in  1  push request; accepted only in a cycle where `write_ready`=1.
- `writedata_left`  in  DATA_WIDTH  left sample, captured with an accepted `write`.
- `writedata_right`  in  DATA_WIDTH  right sample, captured with an accepted `write`.
- `write_ready`  out  1  FIFO not full.
- `AUD_BCLK`  in  1  codec bit clock; asynchronous to `CLOCK_50`.
- `AUD_DACLRCK`  in  1  codec frame clock; low = left, high = right; asynchronous.
- `AUD_DACDAT`  out  1  serial DAC data, registered.
- `underflow`  out  1  sticky; set when a frame starts with the FIFO empty.

## Operation

- **Synchronizers:** `AUD_BCLK` and `AUD_DACLRCK` each pass through 2 flops, plus a third flop for edge detection.
  - `bclk_fall`: one-cycle pulse when the synced BCLK goes 1→0.
  - `lr_fall`, `lr_rise`: one-cycle pulses on the synced LRCK edges.
- **FIFO:** `FIFO_DEPTH` × 2·DATA_WIDTH, with read/write pointers and a count.
  - A push occurs when `write && write_ready`.
  - `write` while `write_ready`=0 is ignored; there is no overwrite.
- **Pop:** occurs only on `lr_fall` (start of a left frame).
  - If count>0: left word → shift register, right word → `right_hold` register.
  - If count=0: load zeros into both, and set `underflow`.
- **Simultaneous push and pop:**
  - Count is unchanged.
  - If empty, the pop sees empty (underflow, zeros) and the push is still stored.
  - If full, `write_ready`=0, so the push is rejected even though a slot frees that cycle.
- **`lr_rise`:** load `right_hold` into the shift register.
- **Serializer FSM** (states IDLE, WAIT, SHIFT, PAD):
  - IDLE (after reset): `AUD_DACDAT`=0; leave only on the first `lr_fall`, which goes to WAIT. An `lr_rise` seen first is ignored, so the first frame is always left.
  - WAIT: shift register loaded; the next `bclk_fall` drives the MSB and goes to SHIFT with bitcnt=DATA_WIDTH−1. This gives the I2S 1-BCLK delay.
  - SHIFT: each `bclk_fall` drives the next bit and decrements bitcnt. The `bclk_fall` after the LSB drives 0 and goes to PAD.
  - PAD: `AUD_DACDAT`=0 until the next LRCK edge.
  - Any LRCK edge in WAIT/SHIFT/PAD reloads the shift register per the pop rules above and goes to WAIT. A truncated word is abandoned; no error is raised.
- **Width:** data is raw two's complement, DATA_WIDTH bits, with no sign extension or scaling.

## Timing

- **Reset values** (immediate on `resetn`=0):
  - `AUD_DACDAT`=0, `underflow`=0, `write_ready`=1.
  - FIFO empty, pointers 0, FSM IDLE.
  - Synchronizer flops = 0.
- **Reset mid-frame:** output drops to 0 at once and queued samples are discarded. After release the block waits in IDLE for the next `lr_fall`.
- **Latency:**
  - `AUD_DACDAT` changes 3 `CLOCK_50` edges after a raw BCLK falling edge: 2 sync + 1 output register.
  - The pop/load takes effect 3 cycles after a raw LRCK edge.
- **`write_ready`:** registered from count. It falls the cycle after the push that fills the FIFO, and rises the cycle after a pop from full.
- **Clock ratio:** BCLK high and low phases must each be ≥3 `CLOCK_50` periods; this holds on-board (~3 MHz BCLK).
- **`underflow`:** stays 1 until reset.

## Test plan

- **Reset:** hold `resetn`=0 with BCLK/LRCK toggling → `AUD_DACDAT`=0, `write_ready`=1, `underflow`=0 throughout. After release with no `lr_fall`, output remains 0.
- **Single frame:** push L=24'hA5_0F3C, R=24'h80_0001; run a 64-BCLK frame → the first bit appears 1 BCLK after LRCK falls. The serial stream reads A50F3C MSB-first, then 0s, then 800001 starting 1 BCLK after LRCK rises.
- **Backpressure:** push 5 pairs back-to-back with no frames → the first 4 are accepted, `write_ready`=0 after the 4th, and the 5th is ignored. Four frames later the output matches pairs 1–4 in order.
- **Underflow:** empty FIFO at `lr_fall` → both channels serialize all zeros and `underflow`=1. A later push plays on the following frame, and `underflow` stays 1.
- **Simultaneous push/pop:** FIFO empty, `write` asserted in the same cycle the pop occurs → zeros are played and `underflow` set; the pushed pair plays on the next frame.
- **Mid-operation reset:** assert `resetn`=0 during the 10th bit of a left word with 3 pairs queued → immediate 0 output and `write_ready`=1. After release, the FIFO is empty and the next frame shows `underflow`.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// I2S playback serializer: buffers stereo pairs in a small FIFO and shifts them
// out MSB-first on AUD_DACDAT, timed by the codec-mastered BCLK/LRCK.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_PAD   = 2'd3;

  logic [2:0]              r_bclkSync;
  logic [2:0]              r_lrSync;
  logic [2*DATA_WIDTH-1:0] r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wrPtr;
  logic [PTR_W-1:0]        r_rdPtr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_writeReady;
  logic [1:0]              r_state;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   r_rightHold;
  logic [BIT_W-1:0]        r_bitCnt;
  logic                    r_dacData;
  logic                    r_underflow;

  logic                    w_bclkFall;
  logic                    w_lrFall;
  logic                    w_lrRise;
  logic                    w_push;
  logic                    w_popValid;
  logic [CNT_W-1:0]        w_countNext;
  logic [2*DATA_WIDTH-1:0] w_headWord;

  // Bit 1 is the synchronized level, bit 2 its one-cycle-old copy.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_bclkSync <= '0;
      r_lrSync   <= '0;
    end else begin
      r_bclkSync <= {r_bclkSync[1:0], AUD_BCLK};
      r_lrSync   <= {r_lrSync[1:0], AUD_DACLRCK};
    end
  end

  assign w_bclkFall = r_bclkSync[2] & ~r_bclkSync[1];
  assign w_lrFall   = r_lrSync[2] & ~r_lrSync[1];
  assign w_lrRise   = ~r_lrSync[2] & r_lrSync[1];

  assign w_push     = write & r_writeReady;
  assign w_popValid = w_lrFall & (r_count != '0);
  assign w_headWord = r_fifoMem[r_rdPtr];

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_popValid)
      w_countNext = r_count + CNT_W'(1);
    else if (!w_push && w_popValid)
      w_countNext = r_count - CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push)
      r_fifoMem[r_wrPtr] <= {writedata_left, writedata_right};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_writeReady <= 1'b1;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_popValid)
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count      <= w_countNext;
      r_writeReady <= (w_countNext != FULL_COUNT);
    end
  end

  // LRCK edges take priority over a coincident BCLK fall, which yields the
  // one-BCLK I2S delay before the MSB.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_rightHold <= '0;
      r_bitCnt    <= '0;
      r_dacData   <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_lrFall) begin
      r_shift     <= w_popValid ? w_headWord[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      r_rightHold <= w_popValid ? w_headWord[DATA_WIDTH-1:0] : '0;
      if (!w_popValid)
        r_underflow <= 1'b1;
      r_state   <= S_WAIT;
      r_dacData <= 1'b0;
    end else if (w_lrRise && r_state != S_IDLE) begin
      r_shift   <= r_rightHold;
      r_state   <= S_WAIT;
      r_dacData <= 1'b0;
    end else if (w_bclkFall) begin
      case (r_state)
        S_WAIT: begin
          r_dacData <= r_shift[DATA_WIDTH-1];
          r_shift   <= r_shift << 1;
          r_bitCnt  <= LAST_BIT;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_bitCnt == '0) begin
            r_dacData <= 1'b0;
            r_state   <= S_PAD;
          end else begin
            r_dacData <= r_shift[DATA_WIDTH-1];
            r_shift   <= r_shift << 1;
            r_bitCnt  <= r_bitCnt - BIT_W'(1);
          end
        end
        default: r_dacData <= 1'b0;
      endcase
    end
  end

  assign write_ready = r_writeReady;
  assign AUD_DACDAT  = r_dacData;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: drives a 64-BCLK I2S codec, captures each
// 32-slot half-frame on rising BCLK and compares against a queue-based model.
module tb_audio_dac_serializer;

  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          write;
  logic [DW-1:0] writedataLeft;
  logic [DW-1:0] writedataRight;
  logic          writeReady;
  logic          bclk;
  logic          lrck;
  logic          dacData;
  logic          underflowOut;

  int nCompared   = 0;
  int nMismatched = 0;
  int lrFallCount = 0;

  logic [2*DW-1:0] modelQ [$];
  logic [31:0]     expQ [$];
  logic [31:0]     capQ [$];
  logic            expUnder;

  logic [31:0] monBuf  = '0;
  int          monSlot = 0;
  logic        monLr   = 1'b1;

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50        (clock),
    .resetn          (resetn),
    .write           (write),
    .writedata_left  (writedataLeft),
    .writedata_right (writedataRight),
    .write_ready     (writeReady),
    .AUD_BCLK        (bclk),
    .AUD_DACLRCK     (lrck),
    .AUD_DACDAT      (dacData),
    .underflow       (underflowOut)
  );

  always #5 clock = ~clock;

  // The codec samples DACDAT on rising BCLK; a half-frame is 32 slots.
  initial begin
    forever begin
      @(posedge bclk);
      if (lrck !== monLr) begin
        monSlot = 0;
        monLr   = lrck;
      end
      monBuf = {monBuf[30:0], dacData};
      monSlot++;
      if (monSlot == 32)
        capQ.push_back(monBuf);
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] halfFrame(input logic [DW-1:0] word);
    return {1'b0, word, 7'b0};
  endfunction

  task automatic modelPop();
    logic [2*DW-1:0] pair;
    if (modelQ.size() > 0) begin
      pair = modelQ.pop_front();
    end else begin
      pair     = '0;
      expUnder = 1'b1;
    end
    expQ.push_back(halfFrame(pair[2*DW-1:DW]));
    expQ.push_back(halfFrame(pair[DW-1:0]));
  endtask

  task automatic bclkCycle();
    bclk = 1'b0;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  task automatic codecFrames(input int n);
    @(posedge clock);
    #3;
    for (int f = 0; f < n; f++) begin
      bclk = 1'b0;
      lrck = 1'b0;
      modelPop();
      lrFallCount++;
      #40;
      bclk = 1'b1;
      #40;
      repeat (31) bclkCycle();
      bclk = 1'b0;
      lrck = 1'b1;
      #40;
      bclk = 1'b1;
      #40;
      repeat (31) bclkCycle();
    end
  endtask

  task automatic compareFrames(input string tag);
    logic [31:0] e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nCompared++;
      assert (capQ.size() > 0) else begin
        nMismatched++;
        $error("[TB] FAIL %s_missing observed=none expected=%h", tag, e);
      end
      if (capQ.size() > 0) begin
        nCompared--;
        checkOutput(tag, capQ.pop_front(), e);
      end
    end
    checkOutput({tag, "_underflow"}, 32'(underflowOut), 32'(expUnder));
    checkOutput({tag, "_ready"}, 32'(writeReady), 32'(modelQ.size() < DEPTH));
  endtask

  task automatic runFrames(input string tag, input int n);
    capQ.delete();
    expQ.delete();
    codecFrames(n);
    compareFrames(tag);
  endtask

  // Call at posedge+1; leaves write asserted at the next posedge+1.
  task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic accept;
    accept = (modelQ.size() < DEPTH);
    checkOutput("push_ready", 32'(writeReady), 32'(accept));
    write          = 1'b1;
    writedataLeft  = l;
    writedataRight = r;
    @(posedge clock);
    #1;
    if (accept)
      modelQ.push_back({l, r});
  endtask

  task automatic endPush();
    write = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int base;

    resetn         = 1'b0;
    write          = 1'b0;
    writedataLeft  = '0;
    writedataRight = '0;
    bclk           = 1'b1;
    lrck           = 1'b1;
    expUnder       = 1'b0;

    // Reset held with codec clocks running
    for (int i = 0; i < 8; i++) begin
      #40;
      bclk = ~bclk;
      if (i % 4 == 0)
        lrck = ~lrck;
      #3;
      checkOutput("rst_dac", 32'(dacData), 32'd0);
      checkOutput("rst_ready", 32'(writeReady), 32'd1);
      checkOutput("rst_underflow", 32'(underflowOut), 32'd0);
    end
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bclkCycle();
      checkOutput("idle_dac", 32'(dacData), 32'd0);
    end

    // Single directed frame
    @(posedge clock);
    #1;
    applyStimulus(24'hA50F3C, 24'h800001);
    endPush();
    runFrames("single", 1);

    // Backpressure: five back-to-back pushes, only four fit
    @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++)
      applyStimulus(DW'($urandom), DW'($urandom));
    endPush();
    checkOutput("full_ready", 32'(writeReady), 32'd0);
    runFrames("backpressure", 4);

    // Underflow then recovery
    runFrames("underflow", 1);
    @(posedge clock);
    #1;
    applyStimulus(DW'($urandom), DW'($urandom));
    endPush();
    runFrames("after_underflow", 1);

    // Push in the same cycle as the pop of an empty FIFO
    capQ.delete();
    expQ.delete();
    base = lrFallCount;
    l = DW'($urandom);
    r = DW'($urandom);
    fork
      codecFrames(2);
      begin
        wait (lrFallCount == base + 1);
        @(posedge clock);
        @(posedge clock);
        #1;
        applyStimulus(l, r);
        endPush();
      end
    join
    compareFrames("simultaneous");

    // Reset during the 10th bit of a left word with three pairs queued
    @(posedge clock);
    #1;
    applyStimulus(24'hFFFFFF, DW'($urandom));
    applyStimulus(DW'($urandom), DW'($urandom));
    applyStimulus(DW'($urandom), DW'($urandom));
    endPush();
    @(posedge clock);
    #3;
    bclk = 1'b0;
    lrck = 1'b0;
    #40;
    bclk = 1'b1;
    #40;
    repeat (9) bclkCycle();
    bclk = 1'b0;
    #35;
    checkOutput("bit10_before_reset", 32'(dacData), 32'd1);
    resetn = 1'b0;
    #1;
    modelQ.delete();
    expUnder = 1'b0;
    checkOutput("midrst_dac", 32'(dacData), 32'd0);
    checkOutput("midrst_ready", 32'(writeReady), 32'd1);
    checkOutput("midrst_underflow", 32'(underflowOut), 32'd0);
    #100;
    resetn = 1'b1;
    lrck   = 1'b1;
    repeat (4) bclkCycle();
    checkOutput("postrst_dac", 32'(dacData), 32'd0);
    runFrames("post_reset", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
